// File: rtl/dircc_output_arbiter.sv
// dircc_output_arbiter
// Packet-atomic round-robin arbiter sharing one Avalon-ST output of the DiRCC
// router among NUM_INPUTS inputs (0=east, 1=north, 2=poets, 3=south, 4=west).
// A packet that wins on its SOP beat owns the output until its EOP beat has
// been accepted. Accepted beats go through a one-entry output register.
module dircc_output_arbiter #(
  parameter int NUM_INPUTS  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_INPUTS-1:0]             in_valid,
  output logic [NUM_INPUTS-1:0]             in_ready,
  input  logic [NUM_INPUTS-1:0]             in_startofpacket,
  input  logic [NUM_INPUTS-1:0]             in_endofpacket,
  input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] in_empty,
  input  logic [NUM_INPUTS-1:0]             in_request,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_startofpacket,
  output logic                              out_endofpacket,
  output logic [EMPTY_WIDTH-1:0]            out_empty,
  output logic [NUM_INPUTS-1:0]             grant,
  output logic [15:0]                       pkt_count,
  output logic                              protocol_error
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Registered state
  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
  logic [NUM_INPUTS-1:0]  grant_q, grant_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [EMPTY_WIDTH-1:0] out_empty_q, out_empty_d;
  logic [15:0]            pkt_count_q, pkt_count_d;
  logic                   protocol_error_q, protocol_error_d;

  // Combinational helpers
  logic                   load;
  logic [NUM_INPUTS-1:0]  eligible;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic                   sel_active;
  logic [IDX_W-1:0]       sel_idx;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_sop;
  logic                   sel_eop;
  logic [EMPTY_WIDTH-1:0] sel_empty;
  logic                   idle_err;
  logic                   lock_err;

  function automatic logic [NUM_INPUTS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return NUM_INPUTS'(1) << idx;
  endfunction

  // Output register can take a beat, and which inputs hold a routed SOP
  always_comb begin
    load     = !out_valid_q || out_ready;
    eligible = in_valid & in_startofpacket & in_request;
  end

  // Round-robin search: first eligible index starting at ptr, wrapping
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Select the input currently allowed to move: lock owner or fresh winner
  always_comb begin
    if (state_q == ST_LOCKED) begin
      sel_active = 1'b1;
      sel_idx    = lock_idx_q;
    end else begin
      sel_active = win_found;
      sel_idx    = win_idx;
    end
  end

  // Ready goes only to the selected input, and only when the output can load
  always_comb begin
    in_ready = '0;
    if (!reset_reset && sel_active && load) begin
      in_ready = idx_onehot(sel_idx);
    end
  end

  // Mux the selected input's beat and detect a completed handshake
  always_comb begin
    sel_data  = in_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_sop   = in_startofpacket[sel_idx];
    sel_eop   = in_endofpacket[sel_idx];
    sel_empty = in_empty[int'(sel_idx)*EMPTY_WIDTH +: EMPTY_WIDTH];
    accept    = in_valid[sel_idx] && in_ready[sel_idx];
  end

  // Framing violations: SOP from a locked owner, or a mid-packet beat in IDLE
  always_comb begin
    idle_err = (state_q == ST_IDLE) &&
               (|(in_valid & in_request & ~in_startofpacket));
    lock_err = (state_q == ST_LOCKED) &&
               in_valid[lock_idx_q] && in_startofpacket[lock_idx_q];
  end

  // Next-state for the output register, lock FSM, counter and error flag
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    lock_idx_d       = lock_idx_q;
    grant_d          = grant_q;
    out_valid_d      = out_valid_q;
    out_data_d       = out_data_q;
    out_sop_d        = out_sop_q;
    out_eop_d        = out_eop_q;
    out_empty_d      = out_empty_q;
    pkt_count_d      = pkt_count_q;
    protocol_error_d = protocol_error_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sop_d   = sel_sop;
      out_eop_d   = sel_eop;
      out_empty_d = sel_empty;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept && sel_eop) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end

    if (state_q == ST_IDLE) begin
      if (accept) begin
        ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
        if (!sel_eop) begin
          state_d    = ST_LOCKED;
          lock_idx_d = win_idx;
          grant_d    = idx_onehot(win_idx);
        end
      end
    end else begin
      if (accept && sel_eop) begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end

    if (idle_err || lock_err) begin
      protocol_error_d = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q          <= ST_IDLE;
      ptr_q            <= '0;
      lock_idx_q       <= '0;
      grant_q          <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_sop_q        <= 1'b0;
      out_eop_q        <= 1'b0;
      out_empty_q      <= '0;
      pkt_count_q      <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      lock_idx_q       <= lock_idx_d;
      grant_q          <= grant_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_sop_q        <= out_sop_d;
      out_eop_q        <= out_eop_d;
      out_empty_q      <= out_empty_d;
      pkt_count_q      <= pkt_count_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_empty         = out_empty_q;
  assign grant             = grant_q;
  assign pkt_count         = pkt_count_q;
  assign protocol_error    = protocol_error_q;

endmodule

// File: tb/tb_dircc_output_arbiter.sv
// Testbench for dircc_output_arbiter: directed scenarios plus randomized
// packet streams checked against a packet-level round-robin model.
module tb_dircc_output_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int EW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  logic            clk_clk = 1'b0;
  logic            reset_reset;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    in_startofpacket;
  logic [N-1:0]    in_endofpacket;
  logic [N*EW-1:0] in_empty;
  logic [N-1:0]    in_request;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_startofpacket;
  logic            out_endofpacket;
  logic [EW-1:0]   out_empty;
  logic [N-1:0]    grant;
  logic [15:0]     pkt_count;
  logic            protocol_error;

  int checks = 0;
  int errors = 0;

  beat_t src_q [N][$];
  beat_t model_q [N][$];
  beat_t exp_q [$];

  dircc_output_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .in_empty(in_empty),
    .in_request(in_request),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_empty(out_empty),
    .grant(grant),
    .pkt_count(pkt_count),
    .protocol_error(protocol_error)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic clear_inputs();
    in_data          = '0;
    in_valid         = '0;
    in_startofpacket = '0;
    in_endofpacket   = '0;
    in_empty         = '0;
    in_request       = '0;
  endtask

  task automatic clear_input(input int i);
    in_valid[i]         = 1'b0;
    in_startofpacket[i] = 1'b0;
    in_endofpacket[i]   = 1'b0;
    in_request[i]       = 1'b0;
  endtask

  task automatic drive_beat(input int i, input logic sop, input logic eop,
                            input logic [DW-1:0] d, input logic [EW-1:0] e,
                            input logic req);
    in_valid[i]            = 1'b1;
    in_startofpacket[i]    = sop;
    in_endofpacket[i]      = eop;
    in_data[i*DW +: DW]    = d;
    in_empty[i*EW +: EW]   = e;
    in_request[i]          = req;
  endtask

  // Leaves the bench just after a rising edge with reset released and inputs idle
  task automatic do_reset();
    clear_inputs();
    out_ready   = 1'b0;
    reset_reset = 1'b1;
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    out_ready   = 1'b1;
    reset_reset = 1'b1;
    drive_beat(0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b1);
    repeat (2) @(posedge clk_clk);
    #1;
    checks++;
    if (in_ready !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 00000", in_ready);
    end
    checks++;
    if ({out_valid, out_startofpacket, out_endofpacket, out_empty, out_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out: got v=%b d=%h expected all zero", out_valid, out_data);
    end
    checks++;
    if ({grant, pkt_count, protocol_error} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_status: got grant=%b cnt=%0d err=%b expected zero",
               grant, pkt_count, protocol_error);
    end
    clear_inputs();
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic test_single_packet();
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive_beat(0, b == 0, b == 3, 32'h11 + b, (b == 3) ? 2'd1 : 2'd0, 1'b1);
      @(negedge clk_clk);
      checks++;
      if (in_ready !== 5'b00001) begin
        errors++;
        $display("[TB] FAIL single_ready beat %0d: got %b expected 00001", b, in_ready);
      end
      @(posedge clk_clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h11 + b ||
          out_startofpacket !== (b == 0) || out_endofpacket !== (b == 3) ||
          out_empty !== ((b == 3) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("[TB] FAIL single_out beat %0d: got v=%b d=%h s=%b e=%b m=%0d expected data %h",
                 b, out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, 32'h11 + b);
      end
      checks++;
      if (grant !== ((b < 3) ? 5'b00001 : 5'b00000)) begin
        errors++;
        $display("[TB] FAIL single_grant beat %0d: got %b expected %b",
                 b, grant, (b < 3) ? 5'b00001 : 5'b00000);
      end
    end
    clear_inputs();
    checks++;
    if (pkt_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d expected 1", pkt_count);
    end
    @(posedge clk_clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_drain: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    out_ready = 1'b1;
    drive_beat(1, 1'b1, 1'b0, 32'h20, 2'd0, 1'b1);
    @(negedge clk_clk);
    checks++;
    if (in_ready !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL lock_sop_ready: got %b expected 00010", in_ready);
    end
    @(posedge clk_clk);
    #1;
    for (int b = 1; b < 3; b++) begin
      drive_beat(1, 1'b0, b == 2, 32'h20 + b, 2'd0, 1'b0);
      drive_beat(4, 1'b1, 1'b1, 32'h40, 2'd3, 1'b1);
      @(negedge clk_clk);
      checks++;
      if (in_ready !== 5'b00010) begin
        errors++;
        $display("[TB] FAIL lock_hold beat %0d: got %b expected 00010", b, in_ready);
      end
      @(posedge clk_clk);
      #1;
    end
    clear_input(1);
    @(negedge clk_clk);
    checks++;
    if (in_ready !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL lock_west_next: got %b expected 10000", in_ready);
    end
    @(posedge clk_clk);
    #1;
    clear_inputs();
    checks++;
    if (out_data !== 32'h40 || out_startofpacket !== 1'b1 || out_endofpacket !== 1'b1 ||
        pkt_count !== 16'd2 || protocol_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_west_out: got d=%h s=%b e=%b cnt=%0d err=%b expected 40 1 1 2 0",
               out_data, out_startofpacket, out_endofpacket, pkt_count, protocol_error);
    end
  endtask

  task automatic test_protocol_error();
    do_reset();
    out_ready = 1'b1;
    drive_beat(0, 1'b1, 1'b0, 32'h50, 2'd0, 1'b1);
    @(posedge clk_clk);
    #1;
    drive_beat(0, 1'b1, 1'b1, 32'h55, 2'd0, 1'b1);
    @(negedge clk_clk);
    checks++;
    if (in_ready !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL perr_fwd_ready: got %b expected 00001", in_ready);
    end
    @(posedge clk_clk);
    #1;
    clear_inputs();
    checks++;
    if (protocol_error !== 1'b1 || out_data !== 32'h55) begin
      errors++;
      $display("[TB] FAIL perr_locked_sop: got err=%b d=%h expected 1 55", protocol_error, out_data);
    end
    repeat (3) @(posedge clk_clk);
    #1;
    checks++;
    if (protocol_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL perr_sticky1: got %b expected 1", protocol_error);
    end
    do_reset();
    checks++;
    if (protocol_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL perr_cleared: got %b expected 0", protocol_error);
    end
    out_ready = 1'b1;
    drive_beat(3, 1'b0, 1'b0, 32'h33, 2'd0, 1'b1);
    @(negedge clk_clk);
    checks++;
    if (in_ready !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL perr_idle_ready: got %b expected 00000", in_ready);
    end
    @(posedge clk_clk);
    #1;
    clear_inputs();
    checks++;
    if (protocol_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL perr_idle_nonsop: got %b expected 1", protocol_error);
    end
    repeat (3) @(posedge clk_clk);
    #1;
    checks++;
    if (protocol_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL perr_sticky2: got %b expected 1", protocol_error);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    drive_beat(0, 1'b1, 1'b1, 32'hE1, 2'd0, 1'b1);
    @(posedge clk_clk);
    #1;
    clear_input(0);
    drive_beat(3, 1'b1, 1'b0, 32'h30, 2'd0, 1'b1);
    @(posedge clk_clk);
    #1;
    checks++;
    if (grant !== 5'b01000 || pkt_count !== 16'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_pre: got grant=%b cnt=%0d v=%b expected 01000 1 1",
               grant, pkt_count, out_valid);
    end
    drive_beat(3, 1'b0, 1'b0, 32'h31, 2'd0, 1'b1);
    #2;
    reset_reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || grant !== 5'b00000 || pkt_count !== 16'd0 || in_ready !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got v=%b grant=%b cnt=%0d rdy=%b expected all zero",
               out_valid, grant, pkt_count, in_ready);
    end
    clear_input(3);
    drive_beat(2, 1'b1, 1'b1, 32'hC2, 2'd0, 1'b1);
    drive_beat(4, 1'b1, 1'b1, 32'hC4, 2'd0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL areset_ready_forced: got %b expected 00000", in_ready);
    end
    @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL areset_ptr0: got %b expected 00100", in_ready);
    end
    @(posedge clk_clk);
    #1;
    clear_inputs();
    checks++;
    if (out_data !== 32'hC2 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_poets_out: got v=%b d=%h expected 1 c2", out_valid, out_data);
    end
  endtask

  // Random packet streams. The expected output order comes from a packet-level
  // round robin over the per-input packet lists.
  task automatic test_stream(input int pkts_per_input, input bit rand_mode);
    int     total;
    int     ptr;
    int     cycles;
    int     other;
    bit     started;
    bit     prev_stall;
    beat_t  prev;
    beat_t  b;
    logic [N-1:0] acc;

    do_reset();
    total = 0;
    other = rand_mode ? int'($urandom_range(0, N - 1)) : -1;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      model_q[i].delete();
      if (i == other) continue;
      for (int p = 0; p < pkts_per_input; p++) begin
        int len;
        len = rand_mode ? int'($urandom_range(1, 4)) : 2;
        for (int k = 0; k < len; k++) begin
          b.data  = {8'(i), 8'(p), 8'(k), 8'($urandom)};
          b.sop   = (k == 0);
          b.eop   = (k == len - 1);
          b.empty = (k == len - 1) ? 2'($urandom) : 2'd0;
          src_q[i].push_back(b);
          model_q[i].push_back(b);
        end
        total++;
      end
    end

    ptr = 0;
    for (int n = 0; n < total; n++) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && model_q[(ptr + k) % N].size() > 0) w = (ptr + k) % N;
      end
      do begin
        b = model_q[w].pop_front();
        exp_q.push_back(b);
      end while (!b.eop);
      ptr = (w + 1) % N;
    end

    cycles     = 0;
    started    = 1'b0;
    prev_stall = 1'b0;
    prev       = '{default: '0};
    while (exp_q.size() > 0 && cycles < 5000) begin
      cycles++;
      for (int i = 0; i < N; i++) begin
        if (i == other) begin
          drive_beat(i, 1'b1, 1'b0, $urandom, 2'd0, 1'b0);
        end else if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          drive_beat(i, b.sop, b.eop, b.data, b.empty, 1'b1);
          if (!b.sop && rand_mode && $urandom_range(0, 3) == 0) in_valid[i] = 1'b0;
        end else begin
          clear_input(i);
        end
      end
      out_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;

      @(negedge clk_clk);
      checks++;
      if (!$onehot0(in_ready) || (other >= 0 && in_ready[other] !== 1'b0) ||
          (out_valid && !out_ready && in_ready !== '0)) begin
        errors++;
        $display("[TB] FAIL stream_ready cycle %0d: got %b with v=%b r=%b blocked=%0d",
                 cycles, in_ready, out_valid, out_ready, other);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev.data || out_startofpacket !== prev.sop ||
            out_endofpacket !== prev.eop || out_empty !== prev.empty) begin
          errors++;
          $display("[TB] FAIL stream_stall_hold cycle %0d: got d=%h expected d=%h held",
                   cycles, out_data, prev.data);
        end
      end
      if (!rand_mode && started) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stream_bubble cycle %0d: got out_valid 0 expected 1", cycles);
        end
      end
      acc = in_valid & in_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !in_startofpacket[i]) begin
          checks++;
          if (grant !== N'(1) << i) begin
            errors++;
            $display("[TB] FAIL stream_grant cycle %0d: got %b expected owner %0d",
                     cycles, grant, i);
          end
        end
      end
      if (out_valid === 1'b1) started = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        b = exp_q.pop_front();
        checks++;
        if (out_data !== b.data || out_startofpacket !== b.sop ||
            out_endofpacket !== b.eop || out_empty !== b.empty) begin
          errors++;
          $display("[TB] FAIL stream_beat cycle %0d: got d=%h s=%b e=%b m=%0d expected d=%h s=%b e=%b m=%0d",
                   cycles, out_data, out_startofpacket, out_endofpacket, out_empty,
                   b.data, b.sop, b.eop, b.empty);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev.data  = out_data;
      prev.sop   = out_startofpacket;
      prev.eop   = out_endofpacket;
      prev.empty = out_empty;

      @(posedge clk_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && i != other) void'(src_q[i].pop_front());
      end
    end
    clear_inputs();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL stream_timeout: got %0d beats outstanding expected 0", exp_q.size());
    end
    checks++;
    if (pkt_count !== 16'(total) || protocol_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_count: got cnt=%0d err=%b expected %0d 0",
               pkt_count, protocol_error, total);
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    out_ready   = 1'b0;
    clear_inputs();
    test_reset();
    test_single_packet();
    test_stream(2, 1'b0);
    test_lock_hold();
    test_protocol_error();
    test_async_reset();
    for (int r = 0; r < 4; r++) begin
      test_stream(6, 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
